// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch sequencer for the core front end. Holds the fetch PC and
//   issues one word fetch at a time on a valid/ready request bus. Each returned
//   {pc,inst} pair is buffered in a small FIFO for decode. A redirect from
//   branch/trap flushes the FIFO and restarts fetch at the new target.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  output FIFO entries (power of 2, 2..8)
//
// Ports
//   clk            core clock
//   rst_n          asynchronous active-low reset
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    new fetch PC, bits [1:0] treated as zero
//   req_valid      fetch request valid
//   req_addr       fetch address (word aligned)
//   req_ready      I-mem accepts the request
//   rsp_valid      I-mem read data valid, one pulse per accepted request
//   rsp_data       instruction word
//   out_valid      FIFO head valid to decode
//   out_pc         PC of the FIFO head
//   out_inst       instruction of the FIFO head
//   out_ready      decode consumes the head
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [63:0]       pc_reg;
  logic [63:0]       inflight_pc_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // FIFO storage; no reset needed since out_valid qualifies the head.
  logic [63:0]       buf_pc_reg   [BUF_DEPTH];
  logic [31:0]       buf_inst_reg [BUF_DEPTH];

  logic        full;
  logic        handshake;
  logic        push;
  logic        pop;
  logic [63:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~64'h3;

  assign full      = (count_reg == FULL_CNT);
  // Gating the request by full guarantees a free slot for the response.
  assign req_valid = (state_reg == S_REQ) && !full;
  assign req_addr  = pc_reg;
  assign handshake = req_valid && req_ready;

  // A redirect flushes the FIFO, so it overrides both push and pop.
  assign push = (state_reg == S_WAIT) && rsp_valid && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count_reg != '0);
  assign out_pc    = buf_pc_reg[rd_ptr_reg];
  assign out_inst  = buf_inst_reg[rd_ptr_reg];

  // Fetch sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      inflight_pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      pc_reg <= redirect_aligned;
      case (state_reg)
        // An accepted request still gets a response; it must be discarded.
        S_REQ:   state_reg <= handshake ? S_DROP : S_REQ;
        S_WAIT:  state_reg <= rsp_valid ? S_REQ : S_DROP;
        default: state_reg <= rsp_valid ? S_REQ : S_DROP;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (handshake) begin
            inflight_pc_reg <= pc_reg;
            pc_reg          <= pc_reg + 64'd4;
            state_reg       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) state_reg <= S_REQ;
        end
        default: begin
          if (rsp_valid) state_reg <= S_REQ;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_reg[wr_ptr_reg]   <= inflight_pc_reg;
      buf_inst_reg[wr_ptr_reg] <= rsp_data;
    end
  end

`ifndef SYNTHESIS
  // A response with no request outstanding indicates a bus protocol error.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(state_reg == S_REQ && rsp_valid));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. The I-mem responder returns
// inst = addr[31:0] + 32'h13 one cycle after acceptance unless held.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Responder state: one outstanding request at most.
  logic        pend;
  logic [63:0] pend_addr;
  logic        rsp_hold;

  fetch_ctrl #(
    .RESET_PC (64'h8000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance one clock. Inputs change and outputs are sampled 1 time unit
  // after the rising edge; the I-mem responder is updated in the same slot.
  task automatic step();
    logic        hs;
    logic        fired;
    logic [63:0] a;
    hs    = req_valid && req_ready && rst_n;
    fired = rsp_valid;
    a     = req_addr;
    @(posedge clk);
    #1;
    if (fired) pend = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    rsp_valid = pend && !rsp_hold;
    rsp_data  = pend_addr[31:0] + 32'h13;
  endtask

  task automatic set_hold(input logic h);
    rsp_hold  = h;
    rsp_valid = pend && !rsp_hold;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b1;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    out_ready      = 1'b1;
    pend           = 1'b0;
    pend_addr      = '0;
    rsp_hold       = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_addr", req_addr, 64'h8000_0000);
    rst_n = 1'b1;
    check("rst_req_valid", 64'(req_valid), 64'd1);

    // 1: streaming, one instruction per two cycles
    step();
    check("t1_wait_req_valid", 64'(req_valid), 64'd0);
    step();
    check("t1_pc0", out_pc, 64'h8000_0000);
    check("t1_inst0", 64'(out_inst), 64'h8000_0013);
    step(); step();
    check("t1_pc1", out_pc, 64'h8000_0004);
    check("t1_inst1", 64'(out_inst), 64'h8000_0017);
    step(); step();
    check("t1_pc2", out_pc, 64'h8000_0008);
    check("t1_inst2", 64'(out_inst), 64'h8000_001B);

    // 2: decode stall fills the FIFO and stops fetch
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t2_req_valid_full", 64'(req_valid), 64'd0);
    check("t2_head_pc", out_pc, 64'h8000_0008);
    check("t2_req_addr", req_addr, 64'h8000_0010);
    out_ready = 1'b1;
    step();
    check("t2_second_pc", out_pc, 64'h8000_000C);
    check("t2_second_inst", 64'(out_inst), 64'h8000_001F);
    check("t2_req_resume", 64'(req_valid), 64'd1);
    check("t2_resume_addr", req_addr, 64'h8000_0010);
    step(); step();
    check("t2_next_pc", out_pc, 64'h8000_0010);
    check("t2_next_inst", 64'(out_inst), 64'h8000_0023);

    // 3: redirect in S_WAIT with response still outstanding
    out_ready = 1'b0;
    set_hold(1'b1);
    step();
    check("t3_in_wait", 64'(req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("t3_flush_out_valid", 64'(out_valid), 64'd0);
    check("t3_drop_req_valid", 64'(req_valid), 64'd0);
    check("t3_target_addr", req_addr, 64'h1000);
    set_hold(1'b0);
    step();
    check("t3_no_push", 64'(out_valid), 64'd0);
    check("t3_req_target", req_addr, 64'h1000);
    check("t3_req_valid", 64'(req_valid), 64'd1);
    step(); step();
    check("t3_fetch_pc", out_pc, 64'h1000);
    check("t3_fetch_inst", 64'(out_inst), 64'h1013);

    // 4: redirect coincident with request handshake
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    step();
    redirect_valid = 1'b0;
    check("t4_drop_req_valid", 64'(req_valid), 64'd0);
    check("t4_flush", 64'(out_valid), 64'd0);
    step();
    check("t4_discarded", 64'(out_valid), 64'd0);
    check("t4_req_addr", req_addr, 64'h2000);
    check("t4_req_valid", 64'(req_valid), 64'd1);
    step(); step();
    check("t4_fetch_pc", out_pc, 64'h2000);
    check("t4_fetch_inst", 64'(out_inst), 64'h2013);

    // 5: redirect with pop and response in the same S_WAIT cycle
    out_ready = 1'b0;
    step();
    check("t5_rsp_present", 64'(rsp_valid), 64'd1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3008;
    step();
    redirect_valid = 1'b0;
    check("t5_empty", 64'(out_valid), 64'd0);
    check("t5_req_valid", 64'(req_valid), 64'd1);
    check("t5_req_addr", req_addr, 64'h3008);
    step(); step();
    check("t5_fetch_pc", out_pc, 64'h3008);
    check("t5_fetch_inst", 64'(out_inst), 64'h301B);

    // 6: address wrap, address hold under backpressure
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("t6_req_addr_top", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_req_valid", 64'(req_valid), 64'd1);
    step();
    check("t6_addr_held", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    req_ready = 1'b1;
    step();
    check("t6_wrap_addr", req_addr, 64'h0);
    step();
    check("t6_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_top_inst", 64'(out_inst), 64'h0000_000F);

    // 6b: asynchronous reset while waiting for a response
    set_hold(1'b1);
    step();
    check("t6b_in_wait", 64'(req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("t6b_rst_addr", req_addr, 64'h8000_0000);
    check("t6b_rst_out_valid", 64'(out_valid), 64'd0);
    pend = 1'b0;
    set_hold(1'b0);
    step();
    rst_n = 1'b1;
    check("t6b_req_valid", 64'(req_valid), 64'd1);
    step(); step();
    check("t6b_fetch_pc", out_pc, 64'h8000_0000);
    check("t6b_fetch_inst", 64'(out_inst), 64'h8000_0013);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
